cordic_phase_sequencer: RTL and testbench

Upstream driver and result collector for the cordic core. It generates a phase-accumulated sequence of 32-bit binary angles, where a full turn is 2^32, so 32'hc0000000 is -90 deg. For each angle it issues a one-cycle start to the cordic and waits the core's fixed latency, because the core has no done signal. It then captures cos/sin and presents each sample on a valid/ready output stream. It serves as the sample source for NCO/mixer logic downstream.

---
 rtl/cordic_phase_sequencer.sv | 124 ++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_sequencer.sv
// cordic_phase_sequencer: drives the cordic core with a phase-accumulated
// sequence of binary angles (full turn = 2^32) and streams out cos/sin.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   go, abort           start / terminate a run
//   phase_init          first angle of a run (latched on go)
//   phase_step          per-sample increment (sampled at each capture)
//   count               samples per run, 0 = continuous (latched on go)
//   busy, done          run in progress / 1-cycle completion pulse
//   cordic_angle/start  to the cordic core
//   cordic_cos/sin      from the cordic core
//   sample_*            valid/ready output stream of captured samples
module cordic_phase_sequencer #(
  parameter int CORDIC_LATENCY = 33,
  parameter int COUNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic               abort,
  input  logic [31:0]        phase_init,
  input  logic [31:0]        phase_step,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic [31:0]        cordic_angle,
  output logic               cordic_start,
  input  logic [31:0]        cordic_cos,
  input  logic [31:0]        cordic_sin,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [31:0]        sample_cos,
  output logic [31:0]        sample_sin,
  output logic [31:0]        sample_phase
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [7:0] LAT = 8'(CORDIC_LATENCY);

  logic [1:0]         state;
  logic [31:0]        phase;
  logic [COUNT_W-1:0] remaining;
  logic [COUNT_W-1:0] count_q;
  logic [7:0]         waitcnt;

  // count_q == 0 marks a continuous run; remaining is not consumed then.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      remaining    <= '0;
      count_q      <= '0;
      waitcnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cordic_angle <= '0;
      cordic_start <= 1'b0;
      sample_valid <= 1'b0;
      sample_cos   <= '0;
      sample_sin   <= '0;
      sample_phase <= '0;
    end else begin
      cordic_start <= 1'b0;
      done         <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        busy         <= 1'b0;
        sample_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              phase     <= phase_init;
              remaining <= count;
              count_q   <= count;
              busy      <= 1'b1;
              state     <= ISSUE;
            end
          end
          ISSUE: begin
            cordic_angle <= phase;
            cordic_start <= 1'b1;
            waitcnt      <= LAT;
            state        <= WAIT;
          end
          WAIT: begin
            // waitcnt is LAT in the start-high cycle, so it
            // reaches 0 in the cycle LAT cycles later.
            if (waitcnt == 8'd0) begin
              sample_cos   <= cordic_cos;
              sample_sin   <= cordic_sin;
              sample_phase <= cordic_angle;
              sample_valid <= 1'b1;
              phase        <= phase + phase_step;
              if (count_q != '0)
                remaining <= remaining - 1'b1;
              state <= HOLD;
            end else begin
              waitcnt <= waitcnt - 8'd1;
            end
          end
          HOLD: begin
            if (sample_ready) begin
              sample_valid <= 1'b0;
              if (count_q != '0 && remaining == '0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                state <= ISSUE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// tb_cordic_phase_sequencer: directed bench with a timestamp-based model
// of the sequencer and a stub cordic (cos = angle, sin = ~angle).
module tb_cordic_phase_sequencer;

  localparam int L = 33;

  logic        clock = 1'b0;
  logic        reset, go, abort;
  logic [31:0] phase_init, phase_step;
  logic [15:0] count;
  logic        busy, done, cordic_start;
  logic [31:0] cordic_angle;
  logic [31:0] cordic_cos = 32'hdeadbeef;
  logic [31:0] cordic_sin = 32'hdeadbeef;
  logic        sample_valid, sample_ready;
  logic [31:0] sample_cos, sample_sin, sample_phase;

  always #5 clock = ~clock;

  cordic_phase_sequencer #(.CORDIC_LATENCY(L), .COUNT_W(16)) dut (
    .clock(clock), .reset(reset), .go(go), .abort(abort),
    .phase_init(phase_init), .phase_step(phase_step), .count(count),
    .busy(busy), .done(done),
    .cordic_angle(cordic_angle), .cordic_start(cordic_start),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_cos(sample_cos), .sample_sin(sample_sin),
    .sample_phase(sample_phase)
  );

  // stub cordic: result appears so it is capturable exactly L cycles
  // after the start-high cycle; garbage until then
  logic [31:0] s_ang = '0;
  int          s_cnt = 0;
  bit          s_pend = 1'b0;
  always @(posedge clock) begin
    if (cordic_start) begin
      s_ang      <= cordic_angle;
      s_cnt      <= L - 1;
      s_pend     <= 1'b1;
      cordic_cos <= 32'hdeadbeef;
      cordic_sin <= 32'hdeadbeef;
    end else if (s_pend) begin
      if (s_cnt == 1) begin
        cordic_cos <= s_ang;
        cordic_sin <= ~s_ang;
        s_pend     <= 1'b0;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // model: expected outputs derived from event times
  int          e = 0;
  bit          m_busy = 0, m_done = 0, m_start = 0, m_valid = 0;
  bit          m_cont = 0;
  logic [31:0] m_next = '0, m_angle = '0;
  logic [31:0] x_cos = '0, x_sin = '0, x_phase = '0;
  logic [15:0] m_left = '0;
  int          st_edge = -1, va_edge = -1;

  // observation log
  logic [31:0] got_ph[$];
  logic [31:0] got_sn[$];
  int          hs_e[$];
  int          st_e[$];
  int          done_cnt = 0;
  int          fv_edge = 0;
  bit          fv_armed = 0;
  int          go_edge = 0;
  bit          cmp_en = 0;

  always @(posedge clock) begin
    e = e + 1;
    if (sample_valid && sample_ready && !reset && !abort) begin
      got_ph.push_back(sample_phase);
      got_sn.push_back(sample_sin);
      hs_e.push_back(e);
    end
    if (cordic_start) st_e.push_back(e);
    if (done) done_cnt++;
    if (fv_armed && sample_valid) begin
      fv_edge  = e;
      fv_armed = 0;
    end

    m_start = 0;
    m_done  = 0;
    if (reset) begin
      m_busy = 0; m_valid = 0; m_cont = 0;
      m_next = '0; m_angle = '0; m_left = '0;
      x_cos = '0; x_sin = '0; x_phase = '0;
      st_edge = -1; va_edge = -1;
    end else if (abort) begin
      m_busy = 0; m_valid = 0;
      st_edge = -1; va_edge = -1;
    end else begin
      if (!m_busy && go) begin
        m_busy  = 1;
        m_next  = phase_init;
        m_left  = count;
        m_cont  = (count == 0);
        st_edge = e + 1;
      end else if (m_valid && sample_ready) begin
        m_valid = 0;
        if (!m_cont && m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          st_edge = e + 1;
        end
      end
      if (e == st_edge) begin
        m_start = 1;
        m_angle = m_next;
        va_edge = e + L + 1;
        st_edge = -1;
      end
      if (e == va_edge) begin
        m_valid = 1;
        x_phase = m_angle;
        x_cos   = m_angle;
        x_sin   = ~m_angle;
        m_next  = m_next + phase_step;
        if (!m_cont) m_left = m_left - 16'd1;
        va_edge = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("cordic_start", 32'(cordic_start), 32'(m_start));
      chk("cordic_angle", cordic_angle, m_angle);
      chk("sample_valid", 32'(sample_valid), 32'(m_valid));
      chk("sample_cos", sample_cos, x_cos);
      chk("sample_sin", sample_sin, x_sin);
      chk("sample_phase", sample_phase, x_phase);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    got_ph.delete();
    got_sn.delete();
    hs_e.delete();
    st_e.delete();
    done_cnt = 0;
    fv_armed = 1;
  endtask

  task automatic pulse_go(input logic [31:0] init, input logic [31:0] stp,
                          input logic [15:0] cnt);
    phase_init = init;
    phase_step = stp;
    count      = cnt;
    go         = 1'b1;
    go_edge    = e + 1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles", nm, busy, n);
    end
    step();
    step();
  endtask

  task automatic wait_valid(input string nm, input int nsamp);
    int n = 0;
    while (!(sample_valid && got_ph.size() == nsamp) && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_timeout: sample %0d never valid", nm, nsamp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] p1[4] = '{32'hc0000000, 32'h00000000, 32'h40000000, 32'h80000000};
  logic [31:0] s1[4] = '{32'h3fffffff, 32'hffffffff, 32'hbfffffff, 32'h7fffffff};
  logic [31:0] p3[3] = '{32'h00000000, 32'h10000000, 32'h20000000};
  logic [31:0] p6[3] = '{32'h00000000, 32'h00000100, 32'h00000200};

  initial begin
    int n;
    int ns;
    reset = 1'b1; go = 1'b0; abort = 1'b0;
    phase_init = '0; phase_step = '0; count = '0;
    sample_ready = 1'b1;
    repeat (3) step();
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_angle", cordic_angle, 32'd0);
    chk("rst_phase", sample_phase, 32'd0);

    // 1: counted run
    clear_log();
    pulse_go(32'hc0000000, 32'h40000000, 16'd4);
    wait_idle("t1");
    chk("t1_nsamp", got_ph.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_phase", got_ph[i], p1[i]);
      chk("t1_sin", got_sn[i], s1[i]);
    end
    chk("t1_first_valid", fv_edge - go_edge, 32'd36);
    chk("t1_first_start", st_e[0] - go_edge, 32'd2);
    chk("t1_period", hs_e[1] - hs_e[0], 32'(L + 3));
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: wrap
    clear_log();
    pulse_go(32'hf0000000, 32'h20000000, 16'd2);
    wait_idle("t2");
    chk("t2_nsamp", got_ph.size(), 32'd2);
    chk("t2_phase0", got_ph[0], 32'hf0000000);
    chk("t2_phase1", got_ph[1], 32'h10000000);
    chk("t2_sin1", got_sn[1], 32'hefffffff);

    // 3: backpressure on sample 2
    clear_log();
    pulse_go(32'h0, 32'h10000000, 16'd3);
    wait_valid("t3", 1);
    sample_ready = 1'b0;
    ns = st_e.size();
    repeat (50) step();
    chk("t3_nostart", st_e.size(), ns);
    chk("t3_held_valid", 32'(sample_valid), 32'd1);
    chk("t3_held_phase", sample_phase, 32'h10000000);
    chk("t3_held_cos", sample_cos, 32'h10000000);
    sample_ready = 1'b1;
    wait_idle("t3");
    chk("t3_nsamp", got_ph.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("t3_phase", got_ph[i], p3[i]);
    chk("t3_restart", st_e[2] - hs_e[1], 32'd2);
    chk("t3_done_cnt", done_cnt, 32'd1);

    // 4: continuous, abort mid-WAIT, restart
    clear_log();
    pulse_go(32'h12345678, 32'h01000000, 16'd0);
    n = 0;
    while (got_ph.size() < 10 && n < 1000) begin
      step();
      n++;
    end
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(sample_valid), 32'd0);
    chk("t4_nsamp", got_ph.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      chk("t4_phase", got_ph[i], 32'h12345678 + 32'(i) * 32'h01000000);
    repeat (5) step();
    chk("t4_no_done", done_cnt, 32'd0);
    clear_log();
    pulse_go(32'h12345678, 32'h01000000, 16'd1);
    wait_idle("t4b");
    chk("t4_restart_n", got_ph.size(), 32'd1);
    chk("t4_restart_ph", got_ph[0], 32'h12345678);
    chk("t4_restart_done", done_cnt, 32'd1);

    // 5: reset during HOLD, go in the same cycle
    clear_log();
    sample_ready = 1'b0;
    pulse_go(32'haaaa0000, 32'h1, 16'd2);
    wait_valid("t5", 0);
    reset = 1'b1;
    go    = 1'b1;
    step();
    reset = 1'b0;
    go    = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(sample_valid), 32'd0);
    chk("t5_cos", sample_cos, 32'd0);
    chk("t5_sin", sample_sin, 32'd0);
    chk("t5_phase", sample_phase, 32'd0);
    chk("t5_angle", cordic_angle, 32'd0);
    repeat (5) step();
    chk("t5_go_ignored", 32'(busy), 32'd0);
    sample_ready = 1'b1;

    // 6: go while busy, go+abort together
    clear_log();
    pulse_go(32'h0, 32'h100, 16'd3);
    phase_init = 32'hffffffff;
    count = 16'd7;
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (20) step();
    go = 1'b1;
    step();
    go = 1'b0;
    wait_valid("t6", 1);
    go = 1'b1;
    step();
    go = 1'b0;
    wait_idle("t6");
    chk("t6_nsamp", got_ph.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("t6_phase", got_ph[i], p6[i]);
    chk("t6_nstart", st_e.size(), 32'd3);
    chk("t6_done_cnt", done_cnt, 32'd1);
    clear_log();
    phase_init = 32'h5;
    count = 16'd1;
    go = 1'b1;
    abort = 1'b1;
    step();
    go = 1'b0;
    abort = 1'b0;
    repeat (5) step();
    chk("t6_abort_busy", 32'(busy), 32'd0);
    chk("t6_abort_start", st_e.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
